nibble_serial_adder_ctrl: RTL and testbench
===========================================

# nibble_serial_adder_ctrl

Sequencing controller that computes a WIDTH-bit sum by driving one internal 4-bit adder slice nibble by nibble, least significant nibble first. Carry is chained between nibbles. It sits between an operand producer and a result consumer, with a valid/ready handshake on each side. It is the multi-word companion to the team's 4-bit binary adder and obeys the same correctness rule: {COUT, SUM} equals A + B.

## Interface
- WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and ≥ 4, otherwise elaboration fails. N = WIDTH/4 nibbles.

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair offered
- in_ready  out  1  controller can accept operands
- a_in  in  WIDTH  operand A
- b_in  in  WIDTH  operand B
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- sum_out  out  WIDTH  result sum (low WIDTH bits of A+B)
- cout_out  out  1  carry out of the most significant nibble
- busy  out  1  high whenever state ≠ IDLE

## Operation
- State machine IDLE → RUN → DONE → IDLE.
- **IDLE**
  - in_ready = 1.
  - On in_valid & in_ready: latch a_in and b_in into internal registers, clear the carry register, set nibble index idx = 0, clear sum_out, go to RUN.
- **RUN**, one nibble per cycle:
  - Compute {c, s} = A[4·idx+3:4·idx] + B[4·idx+3:4·idx] + carry, a 5-bit result.
  - Write s into sum_out[4·idx+3:4·idx].
  - carry ← c; idx ← idx + 1.
  - At idx = N−1: cout_out ← c, go to DONE.
- **DONE**
  - out_valid = 1.
  - sum_out and cout_out are held stable.
  - On out_ready: go to IDLE.
- Outputs decode from state: in_ready = (IDLE), out_valid = (DONE), busy = (state ≠ IDLE).
- Arithmetic: all nibble sums are 5 bits; no truncation before the carry is extracted.
- Invariant whenever out_valid = 1: {cout_out, sum_out} == a_latched + b_latched, compared at WIDTH+1 bits.
- in_valid is ignored in RUN and DONE; no operands are dropped silently because in_ready is low there.
- Changes on a_in/b_in after acceptance have no effect.
- out_ready asserted outside DONE has no effect.
- sum_out changes nibble by nibble during RUN and is meaningful only while out_valid = 1. After the output handshake it holds its value until the next acceptance.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert usage assumed by system):
  - state = IDLE, idx = 0, carry = 0, operand registers = 0.
  - sum_out = 0, cout_out = 0, out_valid = 0, busy = 0, in_ready = 1.
- Acceptance at edge E0. Nibble k is processed at edge E(k+1).
- out_valid rises after edge EN, i.e. latency of N cycles from the accept edge (4 for WIDTH = 16).
- With out_ready held high, the output handshake occurs at EN+1 and in_ready returns high after EN+1. The earliest next accept is EN+2, giving a period of N+2 cycles.
- Backpressure: out_valid stays high for any number of cycles until out_ready; outputs do not change meanwhile.
- Reset during RUN or DONE:
  - Operation is aborted immediately and no out_valid pulse follows.
  - All outputs take their reset values.
- No combinational path from in_valid or out_ready to any output.

## Test plan
- Reset check: hold rst_n low mid-clock, then release → in_ready = 1, out_valid = 0, busy = 0, sum_out = 0x0000, cout_out = 0.
- Basic add (WIDTH = 16): 0x1234 + 0x4321 with out_ready = 1 → out_valid exactly 4 cycles after the accept edge; sum_out = 0x5555, cout_out = 0; busy high for 5 cycles.
- Full carry ripple: 0xFFFF + 0x0001 → sum_out = 0x0000, cout_out = 1. Also 0x0FFF + 0x0001 → 0x1000, cout_out = 0.
- Backpressure: 0xFFFF + 0xFFFF with out_ready low for 3 cycles after out_valid; in_valid held high with 0x1111/0x1111 → out_valid held, sum_out = 0xFFFE and cout_out = 1 stable, in_ready = 0 throughout, second op accepted only after the handshake.
- Reset mid-operation: accept 0xAAAA + 0x5555, pull rst_n low 2 cycles later → no out_valid. Then 0x00FF + 0x0F01 → sum_out = 0x1000, cout_out = 0, with correct 4-cycle latency.
- Back-to-back with out_ready tied high and in_valid held: 0x8000 + 0x8000, then 0x0007 + 0x0009 → results 0x0000/1 and 0x0010/0; accept edges are 6 cycles apart.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl
// Adds two WIDTH-bit operands through a single 4-bit adder slice, one nibble
// per cycle, least significant nibble first, with the carry chained between
// nibbles. Operands arrive and results leave through valid/ready handshakes.
// Every output comes straight from a flop, so nothing on the outputs depends
// combinationally on in_valid or out_ready.
`timescale 1ns/1ps

module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic             busy
);

  localparam int N     = WIDTH / 4;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  // Refuse to elaborate when the operands cannot be split into whole nibbles.
  generate
    if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_bad_width
      $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [IDX_W-1:0] r_idx;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic [4:0]       w_nib;
  logic             w_last;

  // The shared 4-bit adder slice: current nibble of A and B plus carry-in,
  // kept at 5 bits so the carry-out is never truncated away.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path; leaving one
    // unassigned on some path would make synthesis infer a latch.
    w_nib  = 5'd0;
    w_last = 1'b0;
    w_nib  = {1'b0, r_a[{r_idx, 2'b00} +: 4]}
           + {1'b0, r_b[{r_idx, 2'b00} +: 4]}
           + {4'd0, r_carry};
    w_last = (r_idx == IDX_W'(N - 1));
  end

  // Sequencer FSM with its datapath registers and registered handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_cout      <= 1'b0;
      r_idx       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register here samples the values from before this clock edge.
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a        <= a_in;
            r_b        <= b_in;
            r_sum      <= '0;
            r_carry    <= 1'b0;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_RUN;
          end
        end

        S_RUN: begin
          r_sum[{r_idx, 2'b00} +: 4] <= w_nib[3:0];
          r_carry                    <= w_nib[4];
          if (w_last) begin
            r_cout      <= w_nib[4];
            r_idx       <= '0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end

        S_DONE: begin
          // Result and carry stay frozen here until the consumer takes them.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign sum_out   = r_sum;
  assign cout_out  = r_cout;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb_nibble_serial_adder_ctrl
// Self-checking bench for the nibble-serial adder controller (WIDTH = 16):
// directed vectors from a table, hand-written reset sequences, then random
// operands checked against plain (WIDTH+1)-bit addition.
`timescale 1ns/1ps

module tb_nibble_serial_adder_ctrl;

  localparam int WIDTH = 16;
  localparam int N     = WIDTH / 4;
  localparam int CLK_P = 10;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum_out;
  logic             cout_out;
  logic             busy;

  int n_checks = 0;
  int n_errors = 0;

  nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_out   (sum_out),
    .cout_out  (cout_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #(CLK_P / 2) clk = ~clk;

  // Hard time limit so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout;
    int               stall;  // cycles out_ready stays low once out_valid rises
    bit               keep;   // keep in_valid high (0x1111 operands) while busy
  } vec_t;

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One full transaction, entered and left just after a falling edge.
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] exp_sum, input logic exp_cout,
                       input int stall, input bit keep, input string tag,
                       output time t_accept);
    int               lat;
    int               busy_cnt;
    logic [WIDTH-1:0] held_sum;
    logic             held_cout;
    check(in_ready === 1'b1, {tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
    a_in      = a;
    b_in      = b;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    @(posedge clk);
    t_accept = $time;
    #1;
    // Operand inputs change right after acceptance; the result must not care.
    in_valid = keep;
    a_in     = keep ? 16'h1111 : WIDTH'($urandom);
    b_in     = keep ? 16'h1111 : WIDTH'($urandom);
    lat      = 0;
    busy_cnt = 0;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      if (busy) busy_cnt++;
      if (in_ready !== 1'b0)
        check(1'b0, {tag, " in_ready low in RUN"}, 32'(in_ready), 32'd0);
      lat++;
      @(negedge clk);
    end
    check(lat == N, {tag, " latency"}, 32'(lat), 32'(N));
    check(sum_out === exp_sum, {tag, " sum_out"}, 32'(sum_out), 32'(exp_sum));
    check(cout_out === exp_cout, {tag, " cout_out"}, 32'(cout_out), 32'(exp_cout));
    held_sum  = sum_out;
    held_cout = cout_out;
    for (int i = 0; i < stall; i++) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      check(out_valid === 1'b1 && in_ready === 1'b0, {tag, " held valid/!ready"},
            {30'd0, out_valid, in_ready}, 32'd2);
      check(sum_out === held_sum && cout_out === held_cout, {tag, " held result"},
            {15'd0, cout_out, sum_out}, {15'd0, held_cout, held_sum});
    end
    out_ready = 1'b1;
    if (busy) busy_cnt++;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check(out_valid === 1'b0 && in_ready === 1'b1 && busy === 1'b0,
          {tag, " idle after handshake"}, {29'd0, out_valid, in_ready, busy}, 32'd2);
    check(sum_out === held_sum, {tag, " sum held after handshake"},
          32'(sum_out), 32'(held_sum));
    check(busy_cnt == N + 1 + stall, {tag, " busy cycles"},
          32'(busy_cnt), 32'(N + 1 + stall));
  endtask

  vec_t vecs[$];

  initial begin
    time t_acc;
    time t_prev;
    bit  prev_keep;
    int  prev_stall;
    bit  saw_valid;

    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_in      = '0;
    b_in      = '0;
    rst_n     = 1'b1;

    vecs.push_back('{16'h1234, 16'h4321, 16'h5555, 1'b0, 0, 1'b0});
    vecs.push_back('{16'hFFFF, 16'h0001, 16'h0000, 1'b1, 0, 1'b0});
    vecs.push_back('{16'h0FFF, 16'h0001, 16'h1000, 1'b0, 0, 1'b0});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1, 3, 1'b1});
    vecs.push_back('{16'h1111, 16'h1111, 16'h2222, 1'b0, 0, 1'b0});
    vecs.push_back('{16'h8000, 16'h8000, 16'h0000, 1'b1, 0, 1'b1});
    vecs.push_back('{16'h0007, 16'h0009, 16'h0010, 1'b0, 0, 1'b0});

    // Reset asserted mid-clock, checked while held and after release.
    #3 rst_n = 1'b0;
    #1;
    check(in_ready === 1'b1 && out_valid === 1'b0 && busy === 1'b0,
          "reset flags", {29'd0, in_ready, out_valid, busy}, 32'd4);
    check(sum_out === 16'h0000 && cout_out === 1'b0, "reset result",
          {15'd0, cout_out, sum_out}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check(in_ready === 1'b1 && out_valid === 1'b0 && busy === 1'b0,
          "post-reset flags", {29'd0, in_ready, out_valid, busy}, 32'd4);

    // Directed table; after a vector with keep set, the next accept must land
    // exactly one full period (N+2 plus any stall) after the previous one.
    prev_keep  = 1'b0;
    prev_stall = 0;
    t_prev     = 0;
    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].exp_sum, vecs[i].exp_cout,
            vecs[i].stall, vecs[i].keep, $sformatf("vec%0d", i), t_acc);
      if (prev_keep)
        check(t_acc - t_prev == time'((N + 2 + prev_stall) * CLK_P),
              $sformatf("vec%0d accept spacing", i),
              32'(t_acc - t_prev), 32'((N + 2 + prev_stall) * CLK_P));
      prev_keep  = vecs[i].keep;
      prev_stall = vecs[i].stall;
      t_prev     = t_acc;
    end
    in_valid = 1'b0;

    // Reset in the middle of RUN aborts the operation without a result.
    a_in     = 16'hAAAA;
    b_in     = 16'h5555;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check(in_ready === 1'b1 && out_valid === 1'b0 && busy === 1'b0,
          "abort reset flags", {29'd0, in_ready, out_valid, busy}, 32'd4);
    check(sum_out === 16'h0000 && cout_out === 1'b0, "abort reset result",
          {15'd0, cout_out, sum_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    check(!saw_valid, "no out_valid after abort", 32'(saw_valid), 32'd0);
    out_ready = 1'b0;
    do_op(16'h00FF, 16'h0F01, 16'h1000, 1'b0, 0, 1'b0, "post-abort", t_acc);

    // Random operands against plain wide addition.
    for (int i = 0; i < 40; i++) begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      logic [WIDTH:0]   ref_sum;
      ra      = WIDTH'($urandom);
      rb      = WIDTH'($urandom);
      ref_sum = {1'b0, ra} + {1'b0, rb};
      do_op(ra, rb, ref_sum[WIDTH-1:0], ref_sum[WIDTH],
            int'($urandom_range(0, 3)), 1'b0, $sformatf("rand%0d", i), t_acc);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
